// File: rtl/contador_limites.sv
// Bounded up/down counter with load clamp, wrap/saturate modes, sticky flags; optional prescaler via CONTADOR_LIMITES_PRESCALER_EN.
// Latency: one edge from request to counterN/tc/ovf/unf; at_max/at_min/err are combinational.
// Backpressure: none; the count holds whenever enable is low, load is pending or the limits are invalid.
module contador_limites #(
    parameter int N         = 8,
    parameter int STEP_W    = 4,
    parameter int PRESC_DIV = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              dec,
    input  logic              load,
    input  logic [N-1:0]      load_value,
    input  logic [STEP_W-1:0] step,
    input  logic              mode_sat,
    input  logic [N-1:0]      limit_lo,
    input  logic [N-1:0]      limit_hi,
    output logic [N-1:0]      counterN,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              at_max,
    output logic              at_min,
    output logic              err
);

    logic               qualify;
    logic               tick;
    logic               do_count;
    logic               do_load;
    logic               up_evt;
    logic               dn_evt;
    logic [N:0]         step_ext;
    logic [N:0]         sum;
    logic signed [N:0]  diff;
    logic [N-1:0]       load_clamped;

    assign err     = limit_lo > limit_hi;
    assign at_max  = counterN == limit_hi;
    assign at_min  = counterN == limit_lo;
    assign do_load = load && !err;
    assign qualify = enable && !load && !err;

    // step is assumed no wider than N, so N+1 bits hold both the sum and the signed difference
    assign step_ext = (N+1)'(step);
    assign sum      = {1'b0, counterN} + step_ext;
    assign diff     = $signed({1'b0, counterN}) - $signed(step_ext);
    assign up_evt   = sum > {1'b0, limit_hi};
    assign dn_evt   = diff < $signed({1'b0, limit_lo});

    always_comb begin
        load_clamped = load_value;
        if (load_value < limit_lo)
            load_clamped = limit_lo;
        else if (load_value > limit_hi)
            load_clamped = limit_hi;
    end

`ifdef CONTADOR_LIMITES_PRESCALER_EN
    localparam int PW = $clog2(PRESC_DIV);
    logic [PW-1:0] presc_cnt;

    // tick marks the qualifying cycle that completes a full PRESC_DIV period
    assign tick = presc_cnt == PW'(PRESC_DIV - 1);

    always_ff @(posedge clock) begin
        if (reset)
            presc_cnt <= '0;
        else if (do_load)
            presc_cnt <= '0;
        else if (qualify)
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
    end
`else
    assign tick = 1'b1;
`endif

    assign do_count = qualify && tick && (step != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            counterN <= '0;
            tc       <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (do_load) begin
                counterN <= load_clamped;
                ovf      <= 1'b0;
                unf      <= 1'b0;
            end else if (do_count) begin
                if (!dec) begin
                    if (up_evt) begin
                        counterN <= mode_sat ? limit_hi : limit_lo;
                        tc       <= 1'b1;
                        ovf      <= 1'b1;
                    end else begin
                        counterN <= sum[N-1:0];
                    end
                end else begin
                    if (dn_evt) begin
                        counterN <= mode_sat ? limit_lo : limit_hi;
                        tc       <= 1'b1;
                        unf      <= 1'b1;
                    end else begin
                        counterN <= diff[N-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_contador_limites.sv
// Scoreboarded random + directed bench for contador_limites against an integer reference model.
module tb_contador_limites;
    localparam int N         = 8;
    localparam int STEP_W    = 4;
    localparam int PRESC_DIV = 4;
`ifdef CONTADOR_LIMITES_PRESCALER_EN
    localparam int NTICK = PRESC_DIV;
`else
    localparam int NTICK = 1;
`endif

    logic              clock = 1'b0;
    logic              reset, enable, dec, load, mode_sat;
    logic [N-1:0]      load_value, limit_lo, limit_hi;
    logic [STEP_W-1:0] step;
    logic [N-1:0]      counterN;
    logic              tc, ovf, unf, at_max, at_min, err;

    always #5 clock = ~clock;

    contador_limites #(.N(N), .STEP_W(STEP_W), .PRESC_DIV(PRESC_DIV)) dut (
        .clock(clock), .reset(reset), .enable(enable), .dec(dec), .load(load),
        .load_value(load_value), .step(step), .mode_sat(mode_sat),
        .limit_lo(limit_lo), .limit_hi(limit_hi), .counterN(counterN),
        .tc(tc), .ovf(ovf), .unf(unf), .at_max(at_max), .at_min(at_min), .err(err)
    );

    typedef struct packed {
        logic [N-1:0] cnt;
        logic tc, ovf, unf, at_max, at_min, err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    int m_cnt = 0, m_presc = 0;
    bit m_tc = 0, m_ovf = 0, m_unf = 0;

    task automatic model(input bit rst, en, dc, ld, input int lv, st, input bit ms, input int lo, hi);
        bit tick;
        int r;
        if (rst) begin
            m_cnt = 0; m_tc = 0; m_ovf = 0; m_unf = 0; m_presc = 0;
            return;
        end
        m_tc = 0;
        if (lo > hi) return;
        if (ld) begin
            m_cnt   = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
            m_ovf   = 0;
            m_unf   = 0;
            m_presc = 0;
            return;
        end
        if (!en) return;
        m_presc++;
        tick = (m_presc == NTICK);
        if (tick) m_presc = 0;
        if (!tick || st == 0) return;
        if (!dc) begin
            r = m_cnt + st;
            if (r <= hi) m_cnt = r;
            else begin m_cnt = ms ? hi : lo; m_tc = 1; m_ovf = 1; end
        end else begin
            r = m_cnt - st;
            if (r >= lo) m_cnt = r;
            else begin m_cnt = ms ? lo : hi; m_tc = 1; m_unf = 1; end
        end
    endtask

    task automatic drive(input bit rst, en, dc, ld, input int lv, st, input bit ms, input int lo, hi);
        exp_t e;
        @(negedge clock);
        reset = rst; enable = en; dec = dc; load = ld; mode_sat = ms;
        load_value = N'(lv); step = STEP_W'(st); limit_lo = N'(lo); limit_hi = N'(hi);
        model(rst, en, dc, ld, lv, st, ms, lo, hi);
        e.cnt    = N'(m_cnt);
        e.tc     = m_tc;
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        e.at_max = (m_cnt == hi);
        e.at_min = (m_cnt == lo);
        e.err    = (lo > hi);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic count_once(input bit dc, input int st, input bit ms, input int lo, hi);
        repeat (NTICK) drive(0, 1, dc, 0, 0, st, ms, lo, hi);
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // monitor: one registered result per clock edge while stimulus is queued
    initial begin
        exp_t e, got;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {counterN, tc, ovf, unf, at_max, at_min, err};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got cnt=%0d tc=%b ovf=%b unf=%b max=%b min=%b err=%b, expected cnt=%0d tc=%b ovf=%b unf=%b max=%b min=%b err=%b",
                             $time, got.cnt, got.tc, got.ovf, got.unf, got.at_max, got.at_min, got.err,
                             e.cnt, e.tc, e.ovf, e.unf, e.at_max, e.at_min, e.err);
                end
            end
        end
    end

    initial begin
        int lo, hi, t;
        reset = 1; enable = 0; dec = 0; load = 0; mode_sat = 0;
        load_value = '0; step = '0; limit_lo = '0; limit_hi = '0;

        // reset dominates load and enable
        drive(1, 1, 0, 1, 'h20, 1, 0, 0, 255);
        drive(1, 1, 0, 1, 'h20, 1, 0, 0, 255);
        chk("rst_cnt", counterN, 0);
        chk("rst_tc", tc, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);

        // wrap up 3..9
        drive(0, 0, 0, 1, 8, 1, 0, 3, 9);
        chk("wrap_load", counterN, 8);
        count_once(0, 1, 0, 3, 9);
        chk("wrap_cnt9", counterN, 9);
        chk("wrap_tc0", tc, 0);
        count_once(0, 1, 0, 3, 9);
        chk("wrap_cnt3", counterN, 3);
        chk("wrap_tc1", tc, 1);
        chk("wrap_ovf", ovf, 1);
        count_once(0, 1, 0, 3, 9);
        chk("wrap_cnt4", counterN, 4);
        chk("wrap_tc_after", tc, 0);
        chk("wrap_ovf_sticky", ovf, 1);

        // saturate down, step 4
        drive(0, 0, 0, 1, 6, 4, 1, 0, 255);
        chk("sat_load_ovf_clr", ovf, 0);
        count_once(1, 4, 1, 0, 255);
        chk("sat_cnt2", counterN, 2);
        chk("sat_tc0", tc, 0);
        count_once(1, 4, 1, 0, 255);
        chk("sat_cnt0a", counterN, 0);
        chk("sat_tc1a", tc, 1);
        count_once(1, 4, 1, 0, 255);
        chk("sat_cnt0b", counterN, 0);
        chk("sat_tc1b", tc, 1);
        chk("sat_unf", unf, 1);

        // load clamp
        drive(0, 0, 0, 1, 200, 1, 0, 0, 100);
        chk("clamp_hi", counterN, 100);
        drive(0, 0, 0, 1, 'hFF, 1, 0, 0, 255);
        chk("clamp_ff", counterN, 255);
        count_once(0, 1, 0, 0, 255);
        chk("wrap_full_cnt", counterN, 0);
        chk("wrap_full_tc", tc, 1);

        // invalid limits freeze everything
        drive(0, 0, 0, 0, 0, 1, 0, 10, 5);
        chk("err_flag", err, 1);
        drive(0, 1, 0, 1, 7, 1, 0, 10, 5);
        chk("err_load_cnt", counterN, 0);
        chk("err_tc", tc, 0);
        chk("err_ovf_hold", ovf, 1);
        drive(0, 1, 1, 0, 0, 3, 0, 10, 5);
        chk("err_cnt_cnt", counterN, 0);
        chk("err_unf_hold", unf, 0);

        // prescaler: 12 enabled cycles from zero
        drive(1, 0, 0, 0, 0, 1, 0, 0, 255);
        repeat (12) drive(0, 1, 0, 0, 0, 1, 0, 0, 255);
`ifdef CONTADOR_LIMITES_PRESCALER_EN
        chk("presc_cnt", counterN, 3);
`else
        chk("presc_cnt", counterN, 12);
`endif

        // randomized blocks with fixed limits per block
        for (int b = 0; b < 120; b++) begin
            lo = $urandom_range(0, 200);
            hi = lo + $urandom_range(0, 55);
            if ($urandom_range(0, 9) == 0) begin lo = 0; hi = 255; end
            if ($urandom_range(0, 9) == 0) begin t = lo; lo = hi + 1; hi = t; if (lo > 255) lo = 255; end
            for (int c = 0; c < 25; c++)
                drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1),
                      $urandom_range(0, 11) == 0, $urandom_range(0, 255), $urandom_range(0, 15),
                      $urandom_range(0, 1), lo, hi);
        end

        repeat (2) @(posedge clock);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
